// File: rtl/sync_dp_ram_param.sv
// ---------------------------------------------------------------------------
// sync_dp_ram_param
//
// Parametrised single-clock simple dual-port RAM: one write port and one
// registered read port. A synchronous reset starts a hardware clear sequencer
// that writes CLEAR_VALUE into every location, one word per cycle, while
// o_busy is high. Strobes are ignored during the clear.
//
// Optional feature macro: SYNC_DP_RAM_BYPASS_EN
//   defined   -> write-first: a same-address read/write returns i_data_in
//   undefined -> read-first : a same-address read/write returns the old word
//
// Parameters:
//   RAM_WIDTH   data word width (>= 1)
//   RAM_DEPTH   number of words (>= 2, need not be a power of two)
//   ADDR_WIDTH  address width, 2**ADDR_WIDTH >= RAM_DEPTH
//   CLEAR_VALUE word written everywhere during clear, returned for
//               out-of-range reads
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset, restarts the clear sequence
//   i_wr_en     write strobe
//   i_wr_addr   write address
//   i_data_in   write data
//   i_rd_en     read strobe
//   i_rd_addr   read address
//   o_data_out  registered read data (holds when no read)
//   o_rd_valid  o_data_out was updated by a read on the last edge
//   o_busy      clear sequence in progress
// ---------------------------------------------------------------------------
module sync_dp_ram_param #(
    parameter int                   RAM_WIDTH   = 16,
    parameter int                   RAM_DEPTH   = 8,
    parameter int                   ADDR_WIDTH  = 3,
    parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [RAM_WIDTH-1:0]  i_data_in,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [RAM_WIDTH-1:0]  o_data_out,
    output logic                  o_rd_valid,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH     = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_clrPtr;
    logic [RAM_WIDTH-1:0]  r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0]  r_dataOut;
    logic                  r_rdValid;

    logic                  w_busy;
    logic                  w_clrLast;
    logic                  w_wrInRange;
    logic                  w_rdInRange;
    logic                  w_wrAccept;
    logic                  w_rdAccept;
    logic [RAM_WIDTH-1:0]  w_rdData;
`ifdef SYNC_DP_RAM_BYPASS_EN
    logic                  w_collide;
`endif

    // Addresses at or beyond RAM_DEPTH only exist for non-power-of-two
    // depths; the extra leading zero keeps the compare unsigned and exact.
    assign w_clrLast   = (r_clrPtr == LP_LAST_ADDR);
    assign w_wrInRange = ({1'b0, i_wr_addr} < LP_DEPTH);
    assign w_rdInRange = ({1'b0, i_rd_addr} < LP_DEPTH);
    assign w_wrAccept  = (r_state == READY) && i_wr_en && w_wrInRange;
    assign w_rdAccept  = (r_state == READY) && i_rd_en;

`ifdef SYNC_DP_RAM_BYPASS_EN
    // A dropped (out-of-range) write never forwards, so the bypass only
    // fires when the write will actually land in the array.
    assign w_collide = i_wr_en && w_wrInRange && (i_wr_addr == i_rd_addr);
`endif

    // State register: reset always restarts the clear, even mid-clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and busy decode. Busy falls on the same edge that writes
    // the last word, because the state leaves CLEAR on that edge.
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy = 1'b1;
                if (w_clrLast) begin
                    w_nextState = READY;
                end
            end
            READY: begin
                w_nextState = READY;
            end
            default: begin
                w_nextState = CLEAR;
            end
        endcase
    end

    // Clear pointer stops at the last address instead of wrapping, so it
    // can never index past the array for non-power-of-two depths.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clrPtr <= '0;
        end else if ((r_state == CLEAR) && !w_clrLast) begin
            r_clrPtr <= r_clrPtr + 1'b1;
        end
    end

    // Storage array: the clear sequencer owns the write port while busy;
    // any access presented together with reset is discarded.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_clrPtr] <= CLEAR_VALUE;
            end else if (w_wrAccept) begin
                r_mem[i_wr_addr] <= i_data_in;
            end
        end
    end

    // Read data selection, including the collision policy and the
    // CLEAR_VALUE response for addresses outside the array.
    always_comb begin
        w_rdData = CLEAR_VALUE;
        if (w_rdInRange) begin
            w_rdData = r_mem[i_rd_addr];
`ifdef SYNC_DP_RAM_BYPASS_EN
            if (w_collide) begin
                w_rdData = i_data_in;
            end
`endif
        end
    end

    // Registered read port: data holds between reads, valid is a one-cycle
    // flag per accepted read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dataOut <= '0;
            r_rdValid <= 1'b0;
        end else if (w_rdAccept) begin
            r_dataOut <= w_rdData;
            r_rdValid <= 1'b1;
        end else begin
            r_rdValid <= 1'b0;
        end
    end

    assign o_data_out = r_dataOut;
    assign o_rd_valid = r_rdValid;
    assign o_busy     = w_busy;

endmodule

// File: tb/tb_sync_dp_ram_param.sv
// ---------------------------------------------------------------------------
// tb_sync_dp_ram_param
//
// Self-checking bench for sync_dp_ram_param. Instance A uses the default
// 8x16 configuration with CLEAR_VALUE 0; instance B uses a 6-deep array
// with a 3-bit address and CLEAR_VALUE 16'h5A5A to cover non-power-of-two
// depth and a reset part-way through the clear.
// ---------------------------------------------------------------------------
module tb_sync_dp_ram_param;

    typedef struct {
        logic        wrEn;
        logic [2:0]  wrAddr;
        logic [15:0] dataIn;
        logic        rdEn;
        logic [2:0]  rdAddr;
        logic        expValid;
        logic [15:0] expData;
    } vec_t;

`ifdef SYNC_DP_RAM_BYPASS_EN
    localparam logic [15:0] COLL_DATA = 16'h00FF;
`else
    localparam logic [15:0] COLL_DATA = 16'h0011;
`endif

    logic        clk;
    logic        rstA, wrEnA, rdEnA, rdValidA, busyA;
    logic [2:0]  wrAddrA, rdAddrA;
    logic [15:0] dataInA, dataOutA;
    logic        rstB, wrEnB, rdEnB, rdValidB, busyB;
    logic [2:0]  wrAddrB, rdAddrB;
    logic [15:0] dataInB, dataOutB;

    int total = 0;
    int bad   = 0;
    int busyCycles;
    vec_t tabA[$];
    vec_t tabB[$];
    vec_t tabC[$];

    sync_dp_ram_param #(
        .RAM_WIDTH(16), .RAM_DEPTH(8), .ADDR_WIDTH(3), .CLEAR_VALUE(16'h0000)
    ) dutA (
        .i_clk(clk), .i_rst(rstA), .i_wr_en(wrEnA), .i_wr_addr(wrAddrA),
        .i_data_in(dataInA), .i_rd_en(rdEnA), .i_rd_addr(rdAddrA),
        .o_data_out(dataOutA), .o_rd_valid(rdValidA), .o_busy(busyA)
    );

    sync_dp_ram_param #(
        .RAM_WIDTH(16), .RAM_DEPTH(6), .ADDR_WIDTH(3), .CLEAR_VALUE(16'h5A5A)
    ) dutB (
        .i_clk(clk), .i_rst(rstB), .i_wr_en(wrEnB), .i_wr_addr(wrAddrB),
        .i_data_in(dataInB), .i_rd_en(rdEnB), .i_rd_addr(rdAddrB),
        .o_data_out(dataOutB), .o_rd_valid(rdValidB), .o_busy(busyB)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic wrEn, input logic [2:0] wrAddr,
                                   input logic [15:0] dataIn, input logic rdEn,
                                   input logic [2:0] rdAddr, input logic expValid,
                                   input logic [15:0] expData);
        vec_t v;
        v.wrEn = wrEn; v.wrAddr = wrAddr; v.dataIn = dataIn;
        v.rdEn = rdEn; v.rdAddr = rdAddr;
        v.expValid = expValid; v.expData = expData;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector into the selected instance (0 = A, 1 = B).
    task automatic applyStimulus(input bit useB, input vec_t v);
        if (!useB) begin
            wrEnA = v.wrEn; wrAddrA = v.wrAddr; dataInA = v.dataIn;
            rdEnA = v.rdEn; rdAddrA = v.rdAddr;
        end else begin
            wrEnB = v.wrEn; wrAddrB = v.wrAddr; dataInB = v.dataIn;
            rdEnB = v.rdEn; rdAddrB = v.rdAddr;
        end
    endtask

    // Apply each vector for one edge and check valid/data 1 unit later.
    task automatic runTable(input bit useB, input string tag, input vec_t tab[$]);
        for (int i = 0; i < tab.size(); i++) begin
            applyStimulus(useB, tab[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s[%0d] valid", tag, i),
                        {15'd0, useB ? rdValidB : rdValidA}, {15'd0, tab[i].expValid});
            checkOutput($sformatf("%s[%0d] data", tag, i),
                        useB ? dataOutB : dataOutA, tab[i].expData);
        end
        applyStimulus(useB, mkVec(0, 0, 0, 0, 0, 0, 0));
    endtask

    // Count cycles with busy high, starting 1 unit after the reset edge.
    // rd_valid must stay low and data_out must hold the given value.
    task automatic measureBusy(input bit useB, input string tag,
                               input logic [15:0] holdData, output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(useB ? busyB : busyA)) break;
            checkOutput($sformatf("%s clear valid c%0d", tag, i),
                        {15'd0, useB ? rdValidB : rdValidA}, 16'd0);
            checkOutput($sformatf("%s clear data c%0d", tag, i),
                        useB ? dataOutB : dataOutA, holdData);
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        applyStimulus(0, mkVec(0, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, mkVec(0, 0, 0, 0, 0, 0, 0));

        // Instance A: reset values, strobes presented during the clear.
        @(posedge clk);
        #1;
        checkOutput("A reset busy", {15'd0, busyA}, 16'd1);
        checkOutput("A reset valid", {15'd0, rdValidA}, 16'd0);
        checkOutput("A reset data", dataOutA, 16'h0000);
        rstA = 1'b0;
        applyStimulus(0, mkVec(1, 3'd2, 16'hBEEF, 1, 3'd2, 0, 0));
        measureBusy(0, "A1", 16'h0000, busyCycles);
        checkOutput("A1 busy cycles", 16'(busyCycles), 16'd8);

        // Ignored write must not land; then fill every word with A5A5.
        tabA.push_back(mkVec(0, 0, 0, 1, 3'd2, 1, 16'h0000));
        for (int a = 0; a < 8; a++)
            tabA.push_back(mkVec(1, 3'(a), 16'hA5A5, 0, 0, 0, 16'h0000));
        tabA.push_back(mkVec(0, 0, 0, 1, 3'd0, 1, 16'hA5A5));
        tabA.push_back(mkVec(0, 0, 0, 1, 3'd7, 1, 16'hA5A5));
        runTable(0, "tabA", tabA);

        // One-cycle reset pulse reruns the clear over the filled array.
        rstA = 1'b1;
        @(posedge clk);
        #1;
        rstA = 1'b0;
        measureBusy(0, "A2", 16'h0000, busyCycles);
        checkOutput("A2 busy cycles", 16'(busyCycles), 16'd8);

        for (int a = 0; a < 8; a++)
            tabC.push_back(mkVec(0, 0, 0, 1, 3'(a), 1, 16'h0000));
        // Write then read next cycle, then idle: data holds, valid drops.
        tabC.push_back(mkVec(1, 3'd5, 16'h1234, 0, 0, 0, 16'h0000));
        tabC.push_back(mkVec(0, 0, 0, 1, 3'd5, 1, 16'h1234));
        tabC.push_back(mkVec(0, 0, 0, 0, 0, 0, 16'h1234));
        // Collision on address 3, then the new word in both builds.
        tabC.push_back(mkVec(1, 3'd3, 16'h0011, 0, 0, 0, 16'h1234));
        tabC.push_back(mkVec(1, 3'd3, 16'h00FF, 1, 3'd3, 1, COLL_DATA));
        tabC.push_back(mkVec(0, 0, 0, 1, 3'd3, 1, 16'h00FF));
        // Simultaneous write/read to different addresses.
        tabC.push_back(mkVec(1, 3'd4, 16'h4444, 1, 3'd5, 1, 16'h1234));
        tabC.push_back(mkVec(0, 0, 0, 1, 3'd4, 1, 16'h4444));
        runTable(0, "tabC", tabC);

        // Instance B: reset at clear cycle 3 restarts the 6-word clear.
        @(posedge clk);
        #1;
        rstB = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("B mid-clear busy", {15'd0, busyB}, 16'd1);
        rstB = 1'b1;
        @(posedge clk);
        #1;
        rstB = 1'b0;
        measureBusy(1, "B", 16'h0000, busyCycles);
        checkOutput("B busy cycles", 16'(busyCycles), 16'd6);

        tabB.push_back(mkVec(1, 3'd7, 16'h7777, 0, 0, 0, 16'h0000));
        tabB.push_back(mkVec(0, 0, 0, 1, 3'd7, 1, 16'h5A5A));
        tabB.push_back(mkVec(0, 0, 0, 1, 3'd1, 1, 16'h5A5A));
        tabB.push_back(mkVec(0, 0, 0, 1, 3'd5, 1, 16'h5A5A));
        tabB.push_back(mkVec(1, 3'd5, 16'h1111, 0, 0, 0, 16'h5A5A));
        tabB.push_back(mkVec(0, 0, 0, 1, 3'd5, 1, 16'h1111));
        tabB.push_back(mkVec(1, 3'd6, 16'h6666, 1, 3'd6, 1, 16'h5A5A));
        tabB.push_back(mkVec(0, 0, 0, 1, 3'd0, 1, 16'h5A5A));
        runTable(1, "tabB", tabB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
